// File: rtl/abm_writer_if.sv
// rtl/abm_writer_if.sv - write-only AXI4 slave loading the ram0/ram1 ABM banks (option: ABM_WLAST_CHECK_EN)
module abm_writer_if #(
  parameter int DW = 512,
  parameter int DD = 16384,
  localparam int BW  = DW / 8,
  localparam int AW  = $clog2(2 * DD * BW),
  localparam int WAW = $clog2(DD)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WAW-1:0]   ram_addr,
  output logic [DW-1:0]    ram_wdata,
  output logic [BW-1:0]    ram0_we,
  output logic [BW-1:0]    ram1_we,
  input  logic [AW-1:0]    S_AXI_AWADDR,
  input  logic             S_AXI_AWVALID,
  output logic             S_AXI_AWREADY,
  input  logic [3:0]       S_AXI_AWID,
  input  logic [7:0]       S_AXI_AWLEN,
  input  logic [2:0]       S_AXI_AWSIZE,
  input  logic [1:0]       S_AXI_AWBURST,
  input  logic             S_AXI_AWLOCK,
  input  logic [3:0]       S_AXI_AWCACHE,
  input  logic [3:0]       S_AXI_AWQOS,
  input  logic [2:0]       S_AXI_AWPROT,
  input  logic [DW-1:0]    S_AXI_WDATA,
  input  logic [BW-1:0]    S_AXI_WSTRB,
  input  logic             S_AXI_WVALID,
  input  logic             S_AXI_WLAST,
  output logic             S_AXI_WREADY,
  output logic [3:0]       S_AXI_BID,
  output logic [1:0]       S_AXI_BRESP,
  output logic             S_AXI_BVALID,
  input  logic             S_AXI_BREADY,
  input  logic [AW-1:0]    S_AXI_ARADDR,
  input  logic             S_AXI_ARVALID,
  input  logic [3:0]       S_AXI_ARID,
  input  logic [7:0]       S_AXI_ARLEN,
  input  logic [2:0]       S_AXI_ARSIZE,
  input  logic [1:0]       S_AXI_ARBURST,
  input  logic             S_AXI_ARLOCK,
  input  logic [3:0]       S_AXI_ARCACHE,
  input  logic [3:0]       S_AXI_ARQOS,
  input  logic [2:0]       S_AXI_ARPROT,
  input  logic             S_AXI_RREADY,
  output logic             S_AXI_ARREADY,
  output logic             S_AXI_RVALID,
  output logic             S_AXI_RLAST,
  output logic [DW-1:0]    S_AXI_RDATA,
  output logic [1:0]       S_AXI_RRESP
);

  localparam int BSH = $clog2(BW);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_DATA, S_RESP} state_t;

  state_t         state_q, state_d;
  logic           awready_q, awready_d;
  logic           wready_q, wready_d;
  logic           bvalid_q, bvalid_d;
  logic [3:0]     bid_q, bid_d;
  logic [1:0]     bresp_q, bresp_d;
  logic [WAW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0]  ram_wdata_q, ram_wdata_d;
  logic [BW-1:0]  ram0_we_q, ram0_we_d;
  logic [BW-1:0]  ram1_we_q, ram1_we_d;
  logic           bank_q, bank_d;
  logic [WAW-1:0] waddr_q, waddr_d;
  logic [7:0]     beat_q, beat_d;
  logic [3:0]     id_q, id_d;
  logic           last_beat;
`ifdef ABM_WLAST_CHECK_EN
  logic [7:0]     len_q, len_d;
  logic           err_q, err_d;
  logic           err_n;
`endif

  assign S_AXI_ARREADY = 1'b0;
  assign S_AXI_RVALID  = 1'b0;
  assign S_AXI_RLAST   = 1'b0;
  assign S_AXI_RDATA   = '0;
  assign S_AXI_RRESP   = 2'b00;

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BID     = bid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign ram_addr      = ram_addr_q;
  assign ram_wdata     = ram_wdata_q;
  assign ram0_we       = ram0_we_q;
  assign ram1_we       = ram1_we_q;

  // Sideband fields that do not influence a full-width INCR write.
  logic unused_ok;
`ifdef ABM_WLAST_CHECK_EN
  assign unused_ok = ^{S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWQOS,
                       S_AXI_AWPROT, S_AXI_AWADDR[BSH-1:0], S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_ARID,
                       S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARLOCK, S_AXI_ARCACHE,
                       S_AXI_ARQOS, S_AXI_ARPROT, S_AXI_RREADY};
`else
  assign unused_ok = ^{S_AXI_AWLEN, beat_q, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWLOCK,
                       S_AXI_AWCACHE, S_AXI_AWQOS, S_AXI_AWPROT, S_AXI_AWADDR[BSH-1:0],
                       S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_ARID, S_AXI_ARLEN, S_AXI_ARSIZE,
                       S_AXI_ARBURST, S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARQOS, S_AXI_ARPROT,
                       S_AXI_RREADY};
`endif

  // Next-state logic: one burst at a time, write pulses last exactly one cycle.
  always_comb begin
    state_d     = state_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram0_we_d   = '0;
    ram1_we_d   = '0;
    bank_d      = bank_q;
    waddr_d     = waddr_q;
    beat_d      = beat_q;
    id_d        = id_q;
    last_beat   = 1'b0;
`ifdef ABM_WLAST_CHECK_EN
    len_d       = len_q;
    err_d       = err_q;
    err_n       = err_q;
`endif
    case (state_q)
      S_INIT: begin
        awready_d = 1'b1;
        state_d   = S_IDLE;
      end
      S_IDLE: begin
        if (S_AXI_AWVALID && awready_q) begin
          bank_d     = S_AXI_AWADDR[AW-1];
          ram_addr_d = S_AXI_AWADDR[AW-2:BSH];
          waddr_d    = S_AXI_AWADDR[AW-2:BSH];
          beat_d     = 8'd0;
          id_d       = S_AXI_AWID;
`ifdef ABM_WLAST_CHECK_EN
          len_d      = S_AXI_AWLEN;
          err_d      = 1'b0;
`endif
          awready_d  = 1'b0;
          wready_d   = 1'b1;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (S_AXI_WVALID && wready_q) begin
          ram_wdata_d = S_AXI_WDATA;
          ram_addr_d  = waddr_q;
          if (bank_q) ram1_we_d = S_AXI_WSTRB;
          else        ram0_we_d = S_AXI_WSTRB;
          // Wrap stays inside the selected bank.
          waddr_d = (waddr_q == WAW'(DD - 1)) ? '0 : waddr_q + WAW'(1);
          beat_d  = beat_q + 8'd1;
`ifdef ABM_WLAST_CHECK_EN
          last_beat = (beat_q == len_q);
          err_n     = err_q | (last_beat ? !S_AXI_WLAST : S_AXI_WLAST);
          err_d     = err_n;
`else
          last_beat = S_AXI_WLAST;
`endif
          if (last_beat) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bid_d    = id_q;
`ifdef ABM_WLAST_CHECK_EN
            bresp_d  = err_n ? 2'b10 : 2'b00;
`else
            bresp_d  = 2'b00;
`endif
            state_d  = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (bvalid_q && S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // State and registered outputs; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_INIT;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= 4'd0;
      bresp_q     <= 2'b00;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram0_we_q   <= '0;
      ram1_we_q   <= '0;
      bank_q      <= 1'b0;
      waddr_q     <= '0;
      beat_q      <= 8'd0;
      id_q        <= 4'd0;
`ifdef ABM_WLAST_CHECK_EN
      len_q       <= 8'd0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bid_q       <= bid_d;
      bresp_q     <= bresp_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram0_we_q   <= ram0_we_d;
      ram1_we_q   <= ram1_we_d;
      bank_q      <= bank_d;
      waddr_q     <= waddr_d;
      beat_q      <= beat_d;
      id_q        <= id_d;
`ifdef ABM_WLAST_CHECK_EN
      len_q       <= len_d;
      err_q       <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_abm_writer_if.sv
// tb/tb_abm_writer_if.sv - scoreboard bench for abm_writer_if
module tb_abm_writer_if;
  localparam int DW  = 512;
  localparam int DD  = 16384;
  localparam int BW  = DW / 8;
  localparam int AW  = 21;
  localparam int WAW = 14;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [WAW-1:0] ram_addr;
  logic [DW-1:0]  ram_wdata;
  logic [BW-1:0]  ram0_we, ram1_we;
  logic [AW-1:0]  awaddr = '0;
  logic           awvalid = 1'b0, awready;
  logic [3:0]     awid = '0;
  logic [7:0]     awlen = '0;
  logic [2:0]     awsize = 3'd6;
  logic [1:0]     awburst = 2'd1;
  logic [DW-1:0]  wdata = '0;
  logic [BW-1:0]  wstrb = '0;
  logic           wvalid = 1'b0, wlast = 1'b0, wready;
  logic [3:0]     bid;
  logic [1:0]     bresp;
  logic           bvalid, bready = 1'b0;
  logic           arready, rvalid, rlast;
  logic [DW-1:0]  rdata;
  logic [1:0]     rresp;

  abm_writer_if #(.DW(DW), .DD(DD)) dut (
    .clk(clk), .reset(reset),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram0_we(ram0_we), .ram1_we(ram1_we),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready), .S_AXI_AWID(awid),
    .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst), .S_AXI_AWLOCK(1'b0),
    .S_AXI_AWCACHE(4'd0), .S_AXI_AWQOS(4'd0), .S_AXI_AWPROT(3'd0),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WLAST(wlast),
    .S_AXI_WREADY(wready), .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR('0), .S_AXI_ARVALID(1'b0), .S_AXI_ARID(4'd0), .S_AXI_ARLEN(8'd0),
    .S_AXI_ARSIZE(3'd0), .S_AXI_ARBURST(2'd0), .S_AXI_ARLOCK(1'b0), .S_AXI_ARCACHE(4'd0),
    .S_AXI_ARQOS(4'd0), .S_AXI_ARPROT(3'd0), .S_AXI_RREADY(1'b0),
    .S_AXI_ARREADY(arready), .S_AXI_RVALID(rvalid), .S_AXI_RLAST(rlast),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp)
  );

  typedef struct packed {
    logic           bank;
    logic [WAW-1:0] addr;
    logic [DW-1:0]  data;
    logic [BW-1:0]  strb;
  } wr_t;
  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_t;

  wr_t exp_wr[$];
  b_t  exp_b[$];
  logic [BW-1:0] b_strb[$];
  logic [DW-1:0] b_data[$];
  logic          b_last[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [BW-1:0] rnd_strb();
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return '0;
    if (sel == 1) return '1;
    return {$urandom, $urandom};
  endfunction

  // Beats for a burst of len+1 with WLAST only on the final beat.
  task automatic gen_beats(input int len);
    b_strb.delete(); b_data.delete(); b_last.delete();
    for (int i = 0; i <= len; i++) begin
      b_strb.push_back(rnd_strb());
      b_data.push_back(rnd_data());
      b_last.push_back(i == len);
    end
  endtask

  // Reference: which beats the slave accepts, where they land, and the B response.
  task automatic model_burst(input bit bank, input int word, input int len, input logic [3:0] id,
                             output int nacc);
    b_t  b;
    bit  err;
    wr_t w;
    err = 0;
`ifdef ABM_WLAST_CHECK_EN
    nacc = len + 1;
    for (int i = 0; i <= len; i++)
      if ((i < len && b_last[i]) || (i == len && !b_last[i])) err = 1;
`else
    nacc = b_last.size();
    for (int i = b_last.size() - 1; i >= 0; i--)
      if (b_last[i]) nacc = i + 1;
`endif
    for (int i = 0; i < nacc; i++) begin
      if (b_strb[i] != '0) begin
        w.bank = bank;
        w.addr = WAW'((word + i) % DD);
        w.data = b_data[i];
        w.strb = b_strb[i];
        exp_wr.push_back(w);
      end
    end
    b.id   = id;
    b.resp = err ? 2'b10 : 2'b00;
    exp_b.push_back(b);
  endtask

  // Waits (bounded) at falling edges for a ready/valid output to be high.
  task automatic wait_hi(input int which, input string name);
    logic v;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      v = (which == 0) ? awready : (which == 1) ? wready : bvalid;
      if (v) return;
    end
    chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic send_aw(input bit bank, input int word, input int len, input logic [3:0] id);
    @(posedge clk); #1;
    awaddr  = {bank, WAW'(word), 6'(($urandom_range(0, 63)))};
    awlen   = 8'(len);
    awid    = id;
    awsize  = 3'($urandom_range(0, 7));
    awburst = 2'($urandom_range(0, 3));
    awvalid = 1'b1;
    wait_hi(0, "awready");
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_beat(input int i, input int gap_max);
    repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
    wdata  = b_data[i];
    wstrb  = b_strb[i];
    wlast  = b_last[i];
    wvalid = 1'b1;
    wait_hi(1, "wready");
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic run_burst(input bit bank, input int word, input int len, input logic [3:0] id,
                           input int gap_max, input int bready_dly);
    int nacc;
    model_burst(bank, word, len, id, nacc);
    send_aw(bank, word, len, id);
    for (int i = 0; i < nacc; i++) send_beat(i, gap_max);
    // Final beat's handshake was at the last edge: BVALID and its write pulse show now.
    @(negedge clk);
    chk("bvalid_rise", bvalid, 1);
    if (b_strb[nacc-1] != '0) chk("last_we_with_bvalid", ((ram0_we | ram1_we) != '0), 1);
    for (int k = 0; k < bready_dly; k++) begin
      @(posedge clk); #1;
      wvalid = 1'b1; wdata = rnd_data(); wstrb = '1; wlast = 1'b1;
      @(negedge clk);
      chk("bvalid_hold", bvalid, 1);
    end
    @(posedge clk); #1;
    wvalid = 1'b0;
    bready = 1'b1;
    wait_hi(2, "bvalid");
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    chk("awready_after_b", awready, 1);
    chk("bvalid_after_b", bvalid, 0);
  endtask

  // Monitor: every write pulse and B handshake is popped and compared.
  always @(negedge clk) begin
    wr_t w;
    b_t  b;
    if (ram0_we != '0 || ram1_we != '0) begin
      if (exp_wr.size() == 0) begin
        chk("unexpected_write", {ram1_we, ram0_we}, 0);
      end else begin
        w = exp_wr.pop_front();
        chk("we_ram0", ram0_we, w.bank ? '0 : w.strb);
        chk("we_ram1", ram1_we, w.bank ? w.strb : '0);
        chk("ram_addr", ram_addr, w.addr);
        chk("ram_wdata", ram_wdata, w.data);
      end
    end
    if (bvalid && bready) begin
      if (exp_b.size() == 0) begin
        chk("unexpected_b", bvalid, 0);
      end else begin
        b = exp_b.pop_front();
        chk("bid", bid, b.id);
        chk("bresp", bresp, b.resp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int len;
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_bid", bid, 0);
    chk("rst_we", {ram1_we, ram0_we}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("awready_1st_cycle", awready, 0);
    @(negedge clk);
    chk("awready_2nd_cycle", awready, 1);

    // 1: single full-strobe beat to bank0 word 0
    b_strb = '{'1}; b_data = '{rnd_data()}; b_last = '{1'b1};
    run_burst(1'b0, 0, 0, 4'd5, 0, 0);

    // 2: bank1 word 10, gapped data, BREADY held off 5 cycles
    gen_beats(3);
    run_burst(1'b1, 10, 3, 4'd9, 3, 5);

    // 3: wrap at the top of bank0
    gen_beats(3);
    for (int i = 0; i < 4; i++) b_strb[i] = '1;
    run_burst(1'b0, DD - 2, 3, 4'd2, 1, 1);

    // 4: single-byte strobe then empty strobe
    gen_beats(2);
    b_strb[0] = BW'(1);
    b_strb[1] = '0;
    run_burst(1'b1, 100, 2, 4'd7, 0, 0);

    // 5: WLAST early on beat 1 of a len=3 burst
    gen_beats(3);
    b_last[1] = 1'b1;
    for (int i = 0; i < 4; i++) b_strb[i] = '1;
    run_burst(1'b0, 50, 3, 4'd11, 1, 2);

    // 6: reset after beat 2 of a len=7 burst
    gen_beats(7);
    for (int i = 0; i < 8; i++) b_strb[i] = '1;
    for (int i = 0; i < 3; i++) exp_wr.push_back('{1'b1, WAW'(200 + i), b_data[i], b_strb[i]});
    send_aw(1'b1, 200, 7, 4'd3);
    for (int i = 0; i < 3; i++) send_beat(i, 0);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    wvalid = 1'b1; wdata = rnd_data(); wstrb = '1; wlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    wvalid = 1'b0;
    @(negedge clk);
    chk("rst_mid_pending_writes", exp_wr.size(), 0);
    chk("rst_mid_bvalid", bvalid, 0);
    gen_beats(1);
    run_burst(1'b0, 7, 1, 4'd6, 0, 0);

    // Random bursts
    for (int n = 0; n < 20; n++) begin
      len = $urandom_range(0, 7);
      gen_beats(len);
      run_burst(1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? DD - 1 - $urandom_range(0, 3) : $urandom_range(0, DD - 1),
                len, 4'($urandom_range(0, 15)), 2, $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    chk("writes_drained", exp_wr.size(), 0);
    chk("b_drained", exp_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
